// File: rtl/free_list_pkg.sv
// Shared sizing constants for the physical-register free list.
// Pointer width is the index width plus one wrap bit.
package free_list_pkg;

  localparam int PROJ_NUM_PHYS_REGS = 64;
  localparam int PROJ_NUM_ARCH_REGS = 32;
  localparam int PROJ_LOG_PHYS      = 6;
  localparam int FREELIST_PTR_BITS  = PROJ_LOG_PHYS + 1;

endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular buffer with a speculative head (rename),
// a commit head (retire) and a tail (reclaim). Optional macro: FREELIST_DOUBLE_FREE_CHECK_EN.
module free_list
  import free_list_pkg::*;
#(
  parameter int NUM_PHYS = PROJ_NUM_PHYS_REGS,
  parameter int NUM_ARCH = PROJ_NUM_ARCH_REGS,
  parameter int LOG_PHYS = PROJ_LOG_PHYS
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Grabbed_regs,
  output logic [LOG_PHYS-1:0] Free_phys_reg,
  output logic                Free_reg_avail,
  output logic [LOG_PHYS:0]   Free_count,
  input  logic                Commit_alloc,
  input  logic                Retire_free_valid,
  input  logic [LOG_PHYS-1:0] Retire_free_reg,
  input  logic                Flush,
  output logic                Underflow_err,
  output logic                Overflow_err,
  output logic                Double_free_err
);

  localparam int PW = LOG_PHYS + 1;

  // Allocation handshake: Free_reg_avail acts as valid for Free_phys_reg and
  // Grabbed_regs as the consumer's take; a take without valid is an underflow
  // and is ignored. Both sides see registered pointers only (no bypass).

  logic [LOG_PHYS-1:0] mem [NUM_PHYS];
  logic [PW-1:0]       spec_head;
  logic [PW-1:0]       commit_head;
  logic [PW-1:0]       tail;

  logic [PW-1:0] spec_count;
  logic [PW-1:0] commit_span;
  logic          full;
  logic          pop_req;
  logic          pop_ok;
  logic          push_req;
  logic          push_ok;
  logic          dup;
  logic          commit_ok;
  logic [PW-1:0] commit_next;
  logic [PW-1:0] spec_next;

  assign spec_count     = tail - spec_head;
  assign commit_span    = tail - commit_head;
  assign full           = (commit_span == PW'(NUM_PHYS));

  assign Free_phys_reg  = mem[spec_head[LOG_PHYS-1:0]];
  assign Free_reg_avail = (spec_count != '0);
  assign Free_count     = spec_count;

  // A flush overrides any pop in the same cycle.
  assign pop_req   = Grabbed_regs && !Flush;
  assign pop_ok    = pop_req && (spec_count != '0);
  // Phys 0 is the hard-wired zero register and never re-enters the list.
  assign push_req  = Retire_free_valid && (Retire_free_reg != '0);
  assign push_ok   = push_req && !full && !dup;
  assign commit_ok = Commit_alloc && (commit_head != spec_head);

  assign commit_next = commit_head + PW'(commit_ok);
  assign spec_next   = Flush ? commit_next : (spec_head + PW'(pop_ok));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= PW'(NUM_PHYS - NUM_ARCH);
    end else begin
      spec_head   <= spec_next;
      commit_head <= commit_next;
      if (push_ok) tail <= tail + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        mem[i] <= (i < NUM_PHYS - NUM_ARCH) ? LOG_PHYS'(NUM_ARCH + i) : '0;
      end
    end else if (push_ok) begin
      mem[tail[LOG_PHYS-1:0]] <= Retire_free_reg;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Underflow_err <= 1'b0;
      Overflow_err  <= 1'b0;
    end else begin
      if (pop_req && (spec_count == '0)) Underflow_err <= 1'b1;
      if (push_req && full)              Overflow_err  <= 1'b1;
    end
  end

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  logic [NUM_PHYS-1:0] is_free;
  logic [NUM_PHYS-1:0] is_free_next;
  logic [NUM_PHYS-1:0] restore_mask;
  logic [PW-1:0]       squash_span;
  logic [PW-1:0]       pos;

  assign dup         = is_free[Retire_free_reg];
  assign squash_span = spec_head - spec_next;

  // Entries between the restored head and the old head were handed out
  // speculatively; a flush marks their registers free again.
  always_comb begin
    restore_mask = '0;
    pos          = '0;
    if (Flush) begin
      for (int k = 0; k < NUM_PHYS; k++) begin
        pos = spec_next + PW'(k);
        if (PW'(k) < squash_span) restore_mask[mem[pos[LOG_PHYS-1:0]]] = 1'b1;
      end
    end
  end

  always_comb begin
    is_free_next = is_free;
    if (pop_ok) is_free_next[Free_phys_reg] = 1'b0;
    is_free_next = is_free_next | restore_mask;
    if (push_ok) is_free_next[Retire_free_reg] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_PHYS; i++) is_free[i] <= (i >= NUM_ARCH);
      Double_free_err <= 1'b0;
    end else begin
      is_free <= is_free_next;
      if (push_req && dup) begin
        Double_free_err <= 1'b1;
        $display("FREELIST: double free %d", Retire_free_reg);
      end
    end
  end
`else
  assign dup             = 1'b0;
  assign Double_free_err = 1'b0;
`endif

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list: the provider side of the rename allocation handshake.
- Supplies the next free physical register (Free_phys_reg / Free_reg_avail) to rename and consumes the Grabbed_regs pop.
- Reclaims the previous mappings of retiring instructions from the ROB commit path.
- Circular buffer with a speculative head (rename pops) and a commit head (retire). Flush restores the speculative head to the commit head, so squashed allocations return in one cycle.

Parameters:
NUM_PHYS, 64, number of physical registers (power of two); buffer depth equals NUM_PHYS
NUM_ARCH, 32, number of architectural registers; phys 0..NUM_ARCH-1 are mapped at reset
LOG_PHYS, 6, log2(NUM_PHYS); pointer width, plus 1 wrap bit

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
Grabbed_regs  in  1  rename pops the head register this cycle
Free_phys_reg  out  LOG_PHYS  register at the speculative head
Free_reg_avail  out  1  speculative count != 0
Free_count  out  LOG_PHYS+1  speculative free entries (tail - spec_head)
Commit_alloc  in  1  a retiring instruction had allocated a destination; advance commit head
Retire_free_valid  in  1  push the previous mapping of the retiring instruction
Retire_free_reg  in  LOG_PHYS  physical register being returned
Flush  in  1  misprediction recovery; spec_head <= commit_head
Underflow_err  out  1  sticky: pop while empty
Overflow_err  out  1  sticky: push while full
Double_free_err  out  1  sticky: see Optional Feature

Behaviour:
- State: mem[NUM_PHYS], spec_head, commit_head, tail. Each is LOG_PHYS+1 bits with a wrap bit.
- Free_phys_reg = mem[spec_head[LOG_PHYS-1:0]]. Free_reg_avail and Free_count derive from registered pointers only; there is no same-cycle bypass of pushes.
- Reset (async, RESET=1):
  - mem[i] = NUM_ARCH+i for i < NUM_PHYS-NUM_ARCH; remaining entries are 0.
  - spec_head = commit_head = 0; tail = NUM_PHYS-NUM_ARCH.
  - Outputs: Free_phys_reg = 32, Free_reg_avail = 1, Free_count = 32, all error flags 0.
- Pop: Grabbed_regs=1 and count!=0 -> spec_head+1 next cycle, so the new head is visible one cycle later. Grabbed_regs=1 with count==0 -> ignored; Underflow_err <= 1.
- Push: Retire_free_valid=1 -> mem[tail] <= Retire_free_reg; tail+1.
  - Retire_free_reg==0 is dropped silently; phys 0 is permanently $zero.
  - A push when tail-commit_head == NUM_PHYS is dropped; Overflow_err <= 1.
- Commit: Commit_alloc=1 -> commit_head+1. Commit_alloc when commit_head == spec_head is ignored.
- Simultaneous pop and push: both apply; count is unchanged.
- Flush=1: spec_head <= commit_head (post-commit value if Commit_alloc is also 1). Pop that cycle is ignored; push that cycle is applied.
- Pointer wrap: index uses low LOG_PHYS bits; full/empty are distinguished by the wrap bit.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight pushes are lost.
- Error flags are sticky until RESET.

Optional Feature:
- Macro: FREELIST_DOUBLE_FREE_CHECK_EN.
- Defined:
  - Keep a NUM_PHYS-bit is_free bitmap, reset to 1 for NUM_ARCH..NUM_PHYS-1.
  - Pop clears the bit of Free_phys_reg; push sets the bit.
  - A push of a register whose bit is already 1 is dropped, sets Double_free_err, and emits $display("FREELIST: double free %d").
  - Flush restores the bitmap by setting bits for entries between the new spec_head and the old spec_head.
- Undefined: no bitmap; Double_free_err tied to 0.

Decomposition:
- config.v constants: PROJ_NUM_PHYS_REGS, PROJ_NUM_ARCH_REGS, PROJ_LOG_PHYS. Parameter defaults derive from these.
- Typedef-style macro for the pointer width: FREELIST_PTR_BITS = PROJ_LOG_PHYS+1.
- No sub-module is required. The buffer is inline regs; mem has one write port and one read port.

Test Plan:
- Reset -> Free_phys_reg=32, Free_count=32, Free_reg_avail=1; 32 consecutive Grabbed_regs -> outputs 32..63 in order, then Free_reg_avail=0.
- Empty, Grabbed_regs=1 -> Free_count stays 0, Underflow_err=1; push reg 40 -> Free_reg_avail=1 and Free_phys_reg=40 the next cycle, not the same cycle.
- Pop 3 (32, 33, 34), Commit_alloc once, Flush -> Free_phys_reg=33, Free_count=31.
- Same cycle: Grabbed_regs=1, Retire_free_valid=1 with reg 5 -> Free_count unchanged (32); reg 5 appears after 63 wraps around.
- Retire_free_reg=0 pushed -> Free_count unchanged, no error flagged.
- With FREELIST_DOUBLE_FREE_CHECK_EN defined: push 45 while 45 is still free -> Double_free_err=1, Free_count unchanged. Without the macro: Double_free_err=0 and the push applies.
